// File: rtl/pipeline_pkg.sv
// Shared types and widths for the 5-stage RISC-V pipeline.
package pipeline_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXMEM,
    FWD_MEMWB,
    FWD_ZERO
  } fwd_sel_e;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
  } id_ex_t;

  // Register match that never fires on x0
  function automatic logic reg_hit(input logic en, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return en && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks zero, EX/MEM, MEM/WB or the stored operand.
module fwd_mux
  import pipeline_pkg::*;
(
  input  logic             fwd_en,
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  stored,
  input  logic             ex_mem_reg_write,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic [XLEN-1:0]  ex_mem_result,
  input  logic             mem_wb_reg_write,
  input  logic [REG_W-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]  mem_wb_result,
  output logic [XLEN-1:0]  op
);

  fwd_sel_e sel;

  // Source select; EX/MEM is the younger producer so it wins over MEM/WB
  always_comb begin
    sel = FWD_RF;
    if (fwd_en) begin
      if (rs == '0)
        sel = FWD_ZERO;
      else if (reg_hit(ex_mem_reg_write, ex_mem_rd, rs))
        sel = FWD_EXMEM;
      else if (reg_hit(mem_wb_reg_write, mem_wb_rd, rs))
        sel = FWD_MEMWB;
    end
  end

  // Operand data path
  always_comb begin
    op = stored;
    case (sel)
      FWD_ZERO:  op = '0;
      FWD_EXMEM: op = ex_mem_result;
      FWD_MEMWB: op = mem_wb_result;
      default:   op = stored;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard detection.
// FORWARDING_EN: defined enables the forwarding network (stall only on
// load-use); undefined passes stored operands through and stalls on any
// in-flight producer match.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  input  logic              ex_mem_reg_write,
  input  logic [4:0]        ex_mem_rd,
  input  logic [XLEN-1:0]   ex_mem_result,
  input  logic              mem_wb_reg_write,
  input  logic [4:0]        mem_wb_rd,
  input  logic [XLEN-1:0]   mem_wb_result,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic              hazard_stall
);

  id_ex_t q, d;
  logic   load_use, dep_hit, hz;
  logic   fwd_en;

`ifdef FORWARDING_EN
  assign fwd_en  = 1'b1;
  assign dep_hit = 1'b0;
`else
  assign fwd_en  = 1'b0;
  // Without forwarding, any used source produced by EX or EX/MEM must wait
  assign dep_hit = id_valid &
    ((id_rs1_used & (reg_hit(q.valid & q.reg_write, q.rd, id_rs1) |
                     reg_hit(ex_mem_reg_write, ex_mem_rd, id_rs1))) |
     (id_rs2_used & (reg_hit(q.valid & q.reg_write, q.rd, id_rs2) |
                     reg_hit(ex_mem_reg_write, ex_mem_rd, id_rs2))));
`endif

  // Load in EX whose result the decode slot needs next cycle
  assign load_use = id_valid & q.mem_read &
    ((id_rs1_used & reg_hit(q.valid, q.rd, id_rs1)) |
     (id_rs2_used & reg_hit(q.valid, q.rd, id_rs2)));

  assign hz           = (load_use | dep_hit) & ~flush;
  assign hazard_stall = hz | ex_stall;

  // Next-state: flush > hold (with operand refresh) > bubble > load
  always_comb begin
    d = q;
    if (flush) begin
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
    end else if (ex_stall) begin
      if (reg_hit(mem_wb_reg_write, mem_wb_rd, q.rs1)) d.op1 = mem_wb_result;
      if (reg_hit(mem_wb_reg_write, mem_wb_rd, q.rs2)) d.op2 = mem_wb_result;
    end else if (hz) begin
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
    end else begin
      d.valid     = id_valid;
      d.pc        = id_pc;
      d.imm       = id_imm;
      d.rs1       = id_rs1;
      d.rs2       = id_rs2;
      d.rd        = id_rd;
      d.reg_write = id_reg_write;
      d.mem_read  = id_mem_read;
      d.mem_write = id_mem_write;
      d.ctrl      = id_ctrl;
      d.op1       = rf_data1;
      d.op2       = rf_data2;
    end
  end

  // Pipeline register
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

  assign ex_valid     = q.valid;
  assign ex_pc        = q.pc;
  assign ex_imm       = q.imm;
  assign ex_rs1       = q.rs1;
  assign ex_rs2       = q.rs2;
  assign ex_rd        = q.rd;
  assign ex_reg_write = q.reg_write;
  assign ex_mem_read  = q.mem_read;
  assign ex_mem_write = q.mem_write;
  assign ex_ctrl      = q.ctrl;

  fwd_mux u_fwd1 (
    .fwd_en(fwd_en), .rs(q.rs1), .stored(q.op1),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
    .op(ex_op1)
  );

  fwd_mux u_fwd2 (
    .fwd_en(fwd_en), .rs(q.rs2), .stored(q.op2),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
    .op(ex_op2)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; expectations follow FORWARDING_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [7:0]  id_ctrl;
  logic [31:0] rf_data1, rf_data2;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_result;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_result;
  logic        flush, ex_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_op1, ex_op2;
  logic        hazard_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
    .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_ctrl(ex_ctrl), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .hazard_stall(hazard_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_ctrl = 0; rf_data1 = 0; rf_data2 = 0;
    ex_mem_reg_write = 0; ex_mem_rd = 0; ex_mem_result = 0;
    mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_result = 0;
    flush = 0; ex_stall = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; id_valid = 1; id_pc = 32'h100; id_rs1 = 2; rf_data1 = 32'h11;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
    checks++; if (ex_op1 !== 32'h0) begin errors++; $display("FAIL reset_op1 got %h exp 0", ex_op1); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", hazard_stall); end
    reset = 0;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL first_load_valid got %b exp 1", ex_valid); end
    checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL first_load_pc got %h exp 100", ex_pc); end
    checks++; if (ex_op1 !== 32'h11) begin errors++; $display("FAIL first_load_op1 got %h exp 11", ex_op1); end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_a, exp_b, exp_c;
    clear_inputs();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1; rf_data1 = 32'h1234;
    tick();
    id_valid = 0;
`ifdef FORWARDING_EN
    exp_a = 32'hDEADBEEF; exp_b = 32'h1;
`else
    exp_a = 32'h1234; exp_b = 32'h1234;
`endif
    ex_mem_reg_write = 1; ex_mem_rd = 5; ex_mem_result = 32'hDEADBEEF;
    #1;
    checks++; if (ex_op1 !== exp_a) begin errors++; $display("FAIL fwd_exmem got %h exp %h", ex_op1, exp_a); end
    mem_wb_reg_write = 1; mem_wb_rd = 5; mem_wb_result = 32'h1;
    #1;
    checks++; if (ex_op1 !== exp_a) begin errors++; $display("FAIL fwd_priority got %h exp %h", ex_op1, exp_a); end
    ex_mem_reg_write = 0;
    #1;
    checks++; if (ex_op1 !== exp_b) begin errors++; $display("FAIL fwd_memwb got %h exp %h", ex_op1, exp_b); end
    mem_wb_reg_write = 0;
    #1;
    checks++; if (ex_op1 !== 32'h1234) begin errors++; $display("FAIL fwd_none got %h exp 1234", ex_op1); end
    // x0 source with producers writing x0
    id_valid = 1; id_rs1 = 0; rf_data1 = 32'h99;
    tick();
    id_valid = 0;
    ex_mem_reg_write = 1; ex_mem_rd = 0; ex_mem_result = 32'hAAAA;
    mem_wb_reg_write = 1; mem_wb_rd = 0; mem_wb_result = 32'hBBBB;
    #1;
`ifdef FORWARDING_EN
    exp_c = 32'h0;
`else
    exp_c = 32'h99;
`endif
    checks++; if (ex_op1 !== exp_c) begin errors++; $display("FAIL x0_no_fwd got %h exp %h", ex_op1, exp_c); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_pc = 32'h1F0; id_rd = 3; id_reg_write = 1; id_mem_read = 1;
    tick();
    id_pc = 32'h200; id_rd = 6; id_mem_read = 0; id_rs2 = 3; id_rs2_used = 1;
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", hazard_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got v=%b rw=%b mr=%b exp 0", ex_valid, ex_reg_write, ex_mem_read); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %b exp 0", hazard_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200) begin
      errors++; $display("FAIL lu_resume got v=%b pc=%h exp 1/200", ex_valid, ex_pc); end
    // Same register but rs2 not actually read
    id_pc = 32'h300; id_rd = 3; id_rs2 = 0; id_rs2_used = 0; id_mem_read = 1;
    tick();
    id_pc = 32'h304; id_rd = 6; id_mem_read = 0; id_rs2 = 3; id_rs2_used = 0;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_unused got %b exp 0", hazard_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h304) begin
      errors++; $display("FAIL lu_unused_load got v=%b pc=%h exp 1/304", ex_valid, ex_pc); end
  endtask

  task automatic test_hold_refresh();
    clear_inputs();
    id_valid = 1; id_pc = 32'h500; id_rs1 = 7; rf_data1 = 32'h10;
    tick();
    id_pc = 32'h504; rf_data1 = 32'hEE; ex_stall = 1;
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL hold_stall_or got %b exp 1", hazard_stall); end
    tick();
    mem_wb_reg_write = 1; mem_wb_rd = 7; mem_wb_result = 32'h55;
    tick();
    mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_result = 0;
    tick();
    ex_stall = 0;
    #1;
    checks++; if (ex_op1 !== 32'h55) begin errors++; $display("FAIL hold_refresh got %h exp 55", ex_op1); end
    checks++; if (ex_pc !== 32'h500 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL hold_keep got pc=%h v=%b exp 500/1", ex_pc, ex_valid); end
  endtask

  task automatic test_flush();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_rd = 3; id_mem_read = 1;
    tick();
    id_rs1 = 3; id_rs1_used = 1; id_mem_read = 0; flush = 1;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL flush_no_hazard got %b exp 0", hazard_stall); end
    ex_stall = 1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++; $display("FAIL flush_wins got v=%b rw=%b mw=%b mr=%b exp 0", ex_valid, ex_reg_write, ex_mem_write, ex_mem_read); end
  endtask

  task automatic test_reset_mid_hold();
    clear_inputs();
    id_valid = 1; id_pc = 32'h600;
    tick();
    ex_stall = 1;
    tick();
    reset = 1; ex_stall = 0;
    tick();
    reset = 0; id_valid = 0;
    #1;
    checks++; if (ex_valid !== 1'b0 || hazard_stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid_hold got v=%b hz=%b exp 0/0", ex_valid, hazard_stall); end
  endtask

  task automatic test_alu_dependency();
    logic exp_hz;
    clear_inputs();
    id_valid = 1; id_rd = 4; id_reg_write = 1;
    tick();
    id_pc = 32'h400; id_rd = 8; id_rs1 = 4; id_rs1_used = 1; rf_data1 = 32'h0;
    #1;
`ifdef FORWARDING_EN
    exp_hz = 1'b0;
`else
    exp_hz = 1'b1;
`endif
    checks++; if (hazard_stall !== exp_hz) begin errors++; $display("FAIL dep_cycle1 got %b exp %b", hazard_stall, exp_hz); end
`ifndef FORWARDING_EN
    tick();
    ex_mem_reg_write = 1; ex_mem_rd = 4; ex_mem_result = 32'h44;
    #1;
    checks++; if (hazard_stall !== 1'b1 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL dep_cycle2 got hz=%b v=%b exp 1/0", hazard_stall, ex_valid); end
    tick();
    ex_mem_reg_write = 0; ex_mem_rd = 0;
    mem_wb_reg_write = 1; mem_wb_rd = 4; mem_wb_result = 32'h44; rf_data1 = 32'h44;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL dep_release got %b exp 0", hazard_stall); end
    tick();
    mem_wb_reg_write = 0;
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_op1 !== 32'h44) begin
      errors++; $display("FAIL dep_capture got v=%b pc=%h op1=%h exp 1/400/44", ex_valid, ex_pc, ex_op1); end
`endif
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_hold_refresh();
    test_flush();
    test_reset_mid_hold();
    test_alu_dependency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
